// File: rtl/clk_activity_monitor.sv
// Heartbeat monitor: synchronizes an asynchronous blink and measures its period.
// It reports lock/loss of the source and flags periods outside the legal window.
module clk_activity_monitor #(
    parameter int CNT_WIDTH  = 26,
    parameter int MIN_PERIOD = 1_000_000,
    parameter int MAX_PERIOD = 40_000_000,
    parameter int TIMEOUT    = 60_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hb_in,
    input  logic                 clear,
    output logic                 alive,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 out_of_range,
    output logic                 range_err_sticky,
    output logic                 lost_sticky
);

    if (!(MIN_PERIOD > 2 && MIN_PERIOD <= MAX_PERIOD && MAX_PERIOD < TIMEOUT &&
          longint'(TIMEOUT) <= (longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_params
        $error("clk_activity_monitor: need 2 < MIN_PERIOD <= MAX_PERIOD < TIMEOUT <= 2^CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] LP_MIN     = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] LP_MAX     = CNT_WIDTH'(MAX_PERIOD);
    localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED, LOST} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1, r_sync2, r_sync3;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_period;
    logic                 r_alive, r_period_valid, r_out_of_range;
    logic                 r_range_err_sticky, r_lost_sticky;

    logic                 w_rise;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_timeout;
    logic                 w_oor;
    logic                 w_latch;
    logic                 w_enter_lost;

    // The incremented count is the distance to the edge being seen now,
    // which is why both the period latch and the timeout compare use it.
    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == LP_TIMEOUT) && !w_rise;
    assign w_oor     = (w_cnt_inc < LP_MIN) || (w_cnt_inc > LP_MAX);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_rise)         w_state_next = SYNC;
                else if (w_timeout) w_state_next = LOST;
            end
            SYNC, LOCKED: begin
                if (w_rise) begin
                    w_state_next = LOCKED;
                    w_latch      = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = LOST;
                end
            end
            LOST: begin
                if (w_rise) w_state_next = SYNC;
            end
            default: w_state_next = SEARCH;
        endcase
        w_enter_lost = (w_state_next == LOST) && (r_state != LOST);
    end

    // NOTE: sequential state uses non-blocking assignments only; the synchronizer
    // flops are reset too so a reset discards any half-seen edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state            <= SEARCH;
            r_sync1            <= 1'b0;
            r_sync2            <= 1'b0;
            r_sync3            <= 1'b0;
            r_cnt              <= '0;
            r_period           <= '0;
            r_alive            <= 1'b0;
            r_period_valid     <= 1'b0;
            r_out_of_range     <= 1'b0;
            r_range_err_sticky <= 1'b0;
            r_lost_sticky      <= 1'b0;
        end else begin
            r_sync1        <= hb_in;
            r_sync2        <= r_sync1;
            r_sync3        <= r_sync2;
            r_state        <= w_state_next;
            r_cnt          <= w_rise ? '0 : w_cnt_inc;
            r_period_valid <= w_latch;
            r_alive        <= (w_state_next == LOCKED);
            if (w_latch) begin
                r_period       <= w_cnt_inc;
                r_out_of_range <= w_oor;
            end
            // Set beats clear when both happen in the same cycle.
            if (w_latch && w_oor) r_range_err_sticky <= 1'b1;
            else if (clear)       r_range_err_sticky <= 1'b0;
            if (w_enter_lost)     r_lost_sticky <= 1'b1;
            else if (clear)       r_lost_sticky <= 1'b0;
        end
    end

    assign alive            = r_alive;
    assign period           = r_period;
    assign period_valid     = r_period_valid;
    assign out_of_range     = r_out_of_range;
    assign range_err_sticky = r_range_err_sticky;
    assign lost_sticky      = r_lost_sticky;

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Bench for clk_activity_monitor: directed scenarios plus random heartbeat
// segments, all compared every cycle against an edge-time based model.
module tb_clk_activity_monitor;

    localparam int CW   = 8;
    localparam int MINP = 8;
    localparam int MAXP = 40;
    localparam int TO   = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hb_in = 1'b0;
    logic          clear = 1'b0;
    logic          alive;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          out_of_range;
    logic          range_err_sticky;
    logic          lost_sticky;

    int tests = 0;
    int fails = 0;

    clk_activity_monitor #(
        .CNT_WIDTH (CW),
        .MIN_PERIOD(MINP),
        .MAX_PERIOD(MAXP),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .hb_in           (hb_in),
        .clear           (clear),
        .alive           (alive),
        .period          (period),
        .period_valid    (period_valid),
        .out_of_range    (out_of_range),
        .range_err_sticky(range_err_sticky),
        .lost_sticky     (lost_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: edge n is the n-th posedge. A heartbeat rise sampled at edge k is
    // acted on at edge k+2. The model remembers the edge of the last anchor
    // (reset or acted-on rise), how many rises have been seen since reset/loss,
    // and whether the source is currently considered lost.
    int   n = 0;
    int   anchor = 0;
    int   seen = 0;
    bit   m_lost = 1'b0;
    bit   m_valid = 1'b0;
    bit   hb_d1, hb_d2, hb_d3;
    bit   exp_alive, exp_pv, exp_oor, exp_rs, exp_ls;
    int   exp_period;

    always @(posedge clk) begin
        bit evt;
        bit set_r;
        bit set_l;
        int elapsed;
        n++;
        if (!reset_n) begin
            anchor = n; seen = 0; m_lost = 1'b0; m_valid = 1'b1;
            hb_d1 = 1'b0; hb_d2 = 1'b0; hb_d3 = 1'b0;
            exp_alive = 1'b0; exp_pv = 1'b0; exp_oor = 1'b0;
            exp_rs = 1'b0; exp_ls = 1'b0; exp_period = 0;
        end else begin
            evt     = hb_d2 && !hb_d3;
            elapsed = n - anchor;
            set_r   = 1'b0;
            set_l   = 1'b0;
            exp_pv  = 1'b0;
            if (evt) begin
                seen++;
                m_lost = 1'b0;
                if (seen >= 2) begin
                    exp_period = elapsed;
                    exp_pv     = 1'b1;
                    exp_oor    = (elapsed < MINP) || (elapsed > MAXP);
                    set_r      = exp_oor;
                end
                anchor = n;
            end else if (!m_lost && elapsed == TO) begin
                m_lost = 1'b1;
                seen   = 0;
                set_l  = 1'b1;
            end
            exp_rs    = set_r ? 1'b1 : (clear ? 1'b0 : exp_rs);
            exp_ls    = set_l ? 1'b1 : (clear ? 1'b0 : exp_ls);
            exp_alive = !m_lost && (seen >= 2);
            hb_d3 = hb_d2; hb_d2 = hb_d1; hb_d1 = hb_in;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("alive",            alive,            exp_alive);
            check("period",           period,           exp_period);
            check("period_valid",     period_valid,     exp_pv);
            check("out_of_range",     out_of_range,     exp_oor);
            check("range_err_sticky", range_err_sticky, exp_rs);
            check("lost_sticky",      lost_sticky,      exp_ls);
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wave(input int per, input int hi, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            hb_in = 1'b1;
            tick(hi);
            hb_in = 1'b0;
            tick(per - hi);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alive"}, alive, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_pv"}, period_valid, 0);
        check({tag, "_oor"}, out_of_range, 0);
        check({tag, "_rs"}, range_err_sticky, 0);
        check({tag, "_ls"}, lost_sticky, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int per;
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Static input from reset: lost exactly at the 64th cycle.
        tick(63);
        check("static_before_to", lost_sticky, 0);
        tick(1);
        check("static_at_to", lost_sticky, 1);
        check("static_period", period, 0);
        check("static_alive", alive, 0);

        // Period 20 relocks from LOST after two edges.
        wave(20, 10, 4);
        check("p20_alive", alive, 1);
        check("p20_period", period, 20);
        check("p20_oor", out_of_range, 0);
        check("p20_ls_held", lost_sticky, 1);

        clear = 1'b1; tick(1); clear = 1'b0;
        check("clear_ls", lost_sticky, 0);
        check("clear_rs", range_err_sticky, 0);

        // Hold static while locked; clear lands on the timeout cycle.
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (!m_lost && (n - anchor) == TO - 1) found = 1'b1;
            else tick(1);
        end
        check("to_align_found", found, 1);
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clear_vs_to_ls", lost_sticky, 1);
        check("clear_vs_to_alive", alive, 0);

        // Out-of-range periods and recovery.
        wave(50, 25, 2);
        check("p50_oor", out_of_range, 1);
        check("p50_rs", range_err_sticky, 1);
        check("p50_period", period, 50);
        wave(20, 10, 2);
        check("p20b_oor", out_of_range, 0);
        check("p20b_rs", range_err_sticky, 1);
        wave(4, 2, 4);
        check("p4_oor", out_of_range, 1);
        check("p4_period", period, 4);

        // Reset mid-LOCKED, then two fresh edges to measure.
        wave(20, 10, 3);
        tick(3);
        reset_n = 1'b0; tick(1);
        check_all_zero("midreset");
        reset_n = 1'b1;
        tick(5);
        wave(20, 10, 1);
        check("rst_edge1_alive", alive, 0);
        wave(20, 10, 1);
        check("rst_edge2_alive", alive, 1);
        check("rst_edge2_period", period, 20);

        // Random segments, judged by the per-cycle model compare.
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 11) == 0) begin
                reset_n = 1'b0; tick(1); reset_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                clear = 1'b1; tick(1); clear = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                tick($urandom_range(10, 90));
            end else begin
                per = $urandom_range(6, 70);
                wave(per, $urandom_range(3, per - 3), $urandom_range(1, 4));
            end
        end
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
